// File: rtl/ledda_pkg.sv
// ledda_pkg: shared constants, state encoding and prescale helper for the
// SB_LEDDA_IP register-write sequencer.
package ledda_pkg;

  // SB_LEDDA_IP register addresses (LEDDADDR[3:0])
  localparam logic [3:0] ADDR_CR0  = 4'h8;
  localparam logic [3:0] ADDR_BR   = 4'h9;
  localparam logic [3:0] ADDR_ONR  = 4'hA;
  localparam logic [3:0] ADDR_OFR  = 4'hB;
  localparam logic [3:0] ADDR_BCRR = 4'h5;
  localparam logic [3:0] ADDR_BCFR = 4'h6;
  localparam logic [3:0] ADDR_PWRR = 4'h1;
  localparam logic [3:0] ADDR_PWRG = 4'h2;
  localparam logic [3:0] ADDR_PWRB = 4'h3;

  // Mask bit index of each register; writes go out in ascending index order
  localparam logic [3:0] IDX_CR0  = 4'd0;
  localparam logic [3:0] IDX_BR   = 4'd1;
  localparam logic [3:0] IDX_ONR  = 4'd2;
  localparam logic [3:0] IDX_OFR  = 4'd3;
  localparam logic [3:0] IDX_BCRR = 4'd4;
  localparam logic [3:0] IDX_BCFR = 4'd5;
  localparam logic [3:0] IDX_PWRR = 4'd6;
  localparam logic [3:0] IDX_PWRG = 4'd7;
  localparam logic [3:0] IDX_PWRB = 4'd8;
  localparam int         NUM_REGS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_GAP,
    ST_FINISH
  } state_t;

  // LEDD prescaler: divides LEDDCLK down to the 64 kHz reference
  function automatic int calc_pre(input int sys_clk_hz);
    return sys_clk_hz / 64000 - 1;
  endfunction

endpackage

// File: rtl/ledda_gamma.sv
// ledda_gamma: square-law brightness map, g = (v*v + 255) >> 8.
// Rounds up so that full scale stays full scale and 1 stays 1.
module ledda_gamma (
  input  logic [7:0] v,
  output logic [7:0] g
);

  // 16-bit square plus rounding term; the maximum (65025+255) still fits 16 bits
  assign g = 8'((16'(v) * 16'(v) + 16'd255) >> 8);

endmodule

// File: rtl/ledda_cfg_seq.sv
// ledda_cfg_seq: runtime-reconfigurable register-write sequencer in front of
// SB_LEDDA_IP. Writes the masked subset of the nine LEDD registers in
// ascending index order, holding LEDDEXE low while writing.
// Optional feature macro: LEDDA_GAMMA_EN (square-law map of PWM fields at latch).
module ledda_cfg_seq
  import ledda_pkg::*;
#(
  parameter int         SYS_CLK_HZ = 48000000,
  parameter logic [5:0] CR0_MODE   = 6'b110101,
  parameter int         GAP_CYCLES = 0,
  parameter bit         AUTO_START = 1'b1,
  parameter logic [7:0] INIT_ONR   = 8'h19,
  parameter logic [7:0] INIT_OFR   = 8'h19,
  parameter logic [7:0] INIT_BCRR  = 8'hE3,
  parameter logic [7:0] INIT_BCFR  = 8'hA3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [8:0] cfg_mask,
  input  logic [7:0] cfg_pwm_r,
  input  logic [7:0] cfg_pwm_g,
  input  logic [7:0] cfg_pwm_b,
  input  logic [7:0] cfg_onr,
  input  logic [7:0] cfg_ofr,
  input  logic [7:0] cfg_bcrr,
  input  logic [7:0] cfg_bcfr,
  output logic       led_cs,
  output logic       led_en,
  output logic       led_exe,
  output logic [3:0] led_addr,
  output logic [7:0] led_dat,
  output logic       busy,
  output logic       done
);

  localparam int         PRE_I = calc_pre(SYS_CLK_HZ);
  localparam logic [9:0] PRE   = 10'(PRE_I);

  if (SYS_CLK_HZ < 64000 || PRE_I > 1023) begin : g_bad_clk
    $error("ledda_cfg_seq: SYS_CLK_HZ yields a prescale outside 0..1023");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("ledda_cfg_seq: GAP_CYCLES must be within 0..15");
  end

  state_t     state;
  logic [8:0] pend;
  logic [3:0] gcnt;
  logic       auto_pend;
  logic [7:0] pwm_r_q, pwm_g_q, pwm_b_q, onr_q, ofr_q, bcrr_q, bcfr_q;
  logic [7:0] pwm_r_in, pwm_g_in, pwm_b_in;
  logic       accept;
  logic       step;
  logic [3:0] nxt_idx;
  logic [3:0] nxt_addr;
  logic [7:0] nxt_dat;
  logic [8:0] nxt_pend;

`ifdef LEDDA_GAMMA_EN
  ledda_gamma u_gamma_r (.v(cfg_pwm_r), .g(pwm_r_in));
  ledda_gamma u_gamma_g (.v(cfg_pwm_g), .g(pwm_g_in));
  ledda_gamma u_gamma_b (.v(cfg_pwm_b), .g(pwm_b_in));
`else
  assign pwm_r_in = cfg_pwm_r;
  assign pwm_g_in = cfg_pwm_g;
  assign pwm_b_in = cfg_pwm_b;
`endif

  function automatic logic [3:0] lowest_set(input logic [8:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // A pending auto-start sequence takes the place of a handshake accept
  assign accept = (state == ST_IDLE) && (auto_pend || (cfg_valid && cfg_ready));

  // Cycles in which the sequencer moves on to the next register or finishes
  assign step = (state == ST_LOAD) ||
                (state == ST_WRITE && GAP_CYCLES == 0) ||
                (state == ST_GAP && gcnt == 4'd0);

  // Address/data of the next pending register and the mask with it removed
  always_comb begin
    nxt_idx  = lowest_set(pend);
    nxt_pend = pend & ~(9'd1 << nxt_idx);
    nxt_addr = ADDR_CR0;
    nxt_dat  = {CR0_MODE, PRE[9:8]};
    case (nxt_idx)
      IDX_BR:   begin nxt_addr = ADDR_BR;   nxt_dat = PRE[7:0]; end
      IDX_ONR:  begin nxt_addr = ADDR_ONR;  nxt_dat = onr_q;    end
      IDX_OFR:  begin nxt_addr = ADDR_OFR;  nxt_dat = ofr_q;    end
      IDX_BCRR: begin nxt_addr = ADDR_BCRR; nxt_dat = bcrr_q;   end
      IDX_BCFR: begin nxt_addr = ADDR_BCFR; nxt_dat = bcfr_q;   end
      IDX_PWRR: begin nxt_addr = ADDR_PWRR; nxt_dat = pwm_r_q;  end
      IDX_PWRG: begin nxt_addr = ADDR_PWRG; nxt_dat = pwm_g_q;  end
      IDX_PWRB: begin nxt_addr = ADDR_PWRB; nxt_dat = pwm_b_q;  end
      default:  ;
    endcase
  end

  // Configuration payload latch; an abandoned sequence is always reloaded before reuse
  always_ff @(posedge clk) begin
    if (accept) begin
      if (auto_pend) begin
        pwm_r_q <= 8'h00;
        pwm_g_q <= 8'h00;
        pwm_b_q <= 8'h00;
        onr_q   <= INIT_ONR;
        ofr_q   <= INIT_OFR;
        bcrr_q  <= INIT_BCRR;
        bcfr_q  <= INIT_BCFR;
      end else begin
        pwm_r_q <= pwm_r_in;
        pwm_g_q <= pwm_g_in;
        pwm_b_q <= pwm_b_in;
        onr_q   <= cfg_onr;
        ofr_q   <= cfg_ofr;
        bcrr_q  <= cfg_bcrr;
        bcfr_q  <= cfg_bcfr;
      end
    end
  end

  // Sequencer FSM with registered bus and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend      <= '0;
      gcnt      <= '0;
      auto_pend <= AUTO_START;
      cfg_ready <= ~AUTO_START;
      busy      <= 1'b0;
      done      <= 1'b0;
      led_cs    <= 1'b0;
      led_en    <= 1'b0;
      led_exe   <= 1'b0;
      led_addr  <= '0;
      led_dat   <= '0;
    end else begin
      done <= 1'b0;
      if (step) begin
        if (|pend) begin
          state    <= ST_WRITE;
          led_cs   <= 1'b1;
          led_en   <= 1'b1;
          led_addr <= nxt_addr;
          led_dat  <= nxt_dat;
          pend     <= nxt_pend;
        end else begin
          state   <= ST_FINISH;
          led_cs  <= 1'b0;
          led_en  <= 1'b0;
          led_exe <= 1'b1;
          done    <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state     <= ST_LOAD;
              pend      <= auto_pend ? 9'h1FF : cfg_mask;
              auto_pend <= 1'b0;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
              led_exe   <= 1'b0;
            end
          end
          ST_WRITE: begin
            state  <= ST_GAP;
            led_cs <= 1'b0;
            led_en <= 1'b0;
            gcnt   <= 4'(GAP_CYCLES - 1);
          end
          ST_GAP: begin
            gcnt <= gcnt - 4'd1;
          end
          ST_FINISH: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ledda_cfg_seq.sv
// tb_ledda_cfg_seq: randomized bench for ledda_cfg_seq. Two instances run
// with GAP_CYCLES=0 and GAP_CYCLES=3; the expected bus trace is built from
// the register table and per-write timing arithmetic.
module tb_ledda_cfg_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid [2];
  logic       cfg_ready [2];
  logic [8:0] cfg_mask  [2];
  logic [7:0] cfg_pwm_r [2];
  logic [7:0] cfg_pwm_g [2];
  logic [7:0] cfg_pwm_b [2];
  logic [7:0] cfg_onr   [2];
  logic [7:0] cfg_ofr   [2];
  logic [7:0] cfg_bcrr  [2];
  logic [7:0] cfg_bcfr  [2];
  logic       led_cs    [2];
  logic       led_en    [2];
  logic       led_exe   [2];
  logic [3:0] led_addr  [2];
  logic [7:0] led_dat   [2];
  logic       busy      [2];
  logic       done      [2];

  int total = 0;
  int bad   = 0;

  logic [3:0] addr_tab [9] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h5, 4'h6, 4'h1, 4'h2, 4'h3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ledda_cfg_seq #(.GAP_CYCLES(g * 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid[g]), .cfg_ready(cfg_ready[g]), .cfg_mask(cfg_mask[g]),
      .cfg_pwm_r(cfg_pwm_r[g]), .cfg_pwm_g(cfg_pwm_g[g]), .cfg_pwm_b(cfg_pwm_b[g]),
      .cfg_onr(cfg_onr[g]), .cfg_ofr(cfg_ofr[g]), .cfg_bcrr(cfg_bcrr[g]), .cfg_bcfr(cfg_bcfr[g]),
      .led_cs(led_cs[g]), .led_en(led_en[g]), .led_exe(led_exe[g]),
      .led_addr(led_addr[g]), .led_dat(led_dat[g]), .busy(busy[g]), .done(done[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gam(input logic [7:0] v);
`ifdef LEDDA_GAMMA_EN
    int p;
    p = (int'(v) * int'(v) + 255) / 256;
    return 8'(p);
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] exp_dat(input int k, input logic [7:0] r, g, b,
                                         onr, ofr, bcrr, bcfr);
    case (k)
      0: return 8'hD6;
      1: return 8'hED;
      2: return onr;
      3: return ofr;
      4: return bcrr;
      5: return bcfr;
      6: return gam(r);
      7: return gam(g);
      default: return gam(b);
    endcase
  endfunction

  // Follows one sequence starting just after its accept edge. Optional poke
  // offers a full-mask config while busy; abort>0 asserts reset at that offset.
  task automatic check_seq(input int i, input logic [8:0] mask,
                           input logic [7:0] r, g, b, onr, ofr, bcrr, bcfr,
                           input bit poke, input int abort);
    logic [11:0] exp_w[$];
    int gap, doff, wk;
    bit is_w, is_d;
    gap = i * 3;
    for (int k = 0; k < 9; k++)
      if (mask[k]) exp_w.push_back({addr_tab[k], exp_dat(k, r, g, b, onr, ofr, bcrr, bcfr)});
    doff = 1 + exp_w.size() * (1 + gap);
    wk = 0;
    for (int o = 0; o <= doff + 1; o++) begin
      @(negedge clk);
      if (o <= doff) begin
        is_w = (o >= 1) && (o < doff) && ((o - 1) % (1 + gap) == 0);
        is_d = (o == doff);
        chk("ctl", 32'({led_cs[i], led_en[i], led_exe[i], done[i]}), 32'({is_w, is_w, is_d, is_d}));
        if (is_w && wk < exp_w.size()) begin
          chk("wr", 32'({led_addr[i], led_dat[i]}), 32'(exp_w[wk]));
          wk++;
        end
        if (o < doff) chk("busy", 32'(busy[i]), 32'd1);
        chk("rdy_lo", 32'(cfg_ready[i]), 32'd0);
      end else begin
        chk("idle", 32'({cfg_ready[i], busy[i], led_exe[i], done[i], led_cs[i]}), 32'(5'b10100));
      end
      if (abort > 0 && o == abort) begin
        rst_n = 1'b0;
        #1;
        chk("rst_now", 32'({led_cs[i], led_en[i], led_exe[i], led_addr[i], led_dat[i],
                            busy[i], done[i], cfg_ready[i]}), 32'd0);
        return;
      end
      if (poke && o == 0) begin
        cfg_mask[i]  = 9'h1FF;
        cfg_pwm_r[i] = 8'($urandom);
        cfg_valid[i] = 1'b1;
      end
      if (poke && o == doff) cfg_valid[i] = 1'b0;
    end
  endtask

  task automatic send(input int i, input logic [8:0] mask,
                      input logic [7:0] r, g, b, onr, ofr, bcrr, bcfr,
                      input bit poke, input int abort);
    int w;
    @(negedge clk);
    cfg_mask[i] = mask;
    cfg_pwm_r[i] = r; cfg_pwm_g[i] = g; cfg_pwm_b[i] = b;
    cfg_onr[i] = onr; cfg_ofr[i] = ofr; cfg_bcrr[i] = bcrr; cfg_bcfr[i] = bcfr;
    cfg_valid[i] = 1'b1;
    w = 0;
    while (!cfg_ready[i] && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept", 32'(cfg_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid[i] = 1'b0;
    // Scramble inputs so only latched values can reach the bus
    cfg_mask[i] = 9'($urandom); cfg_pwm_r[i] = 8'($urandom); cfg_pwm_g[i] = 8'($urandom);
    cfg_pwm_b[i] = 8'($urandom); cfg_onr[i] = 8'($urandom); cfg_ofr[i] = 8'($urandom);
    cfg_bcrr[i] = 8'($urandom); cfg_bcfr[i] = 8'($urandom);
    check_seq(i, mask, r, g, b, onr, ofr, bcrr, bcfr, poke, abort);
  endtask

  task automatic auto_both();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      check_seq(0, 9'h1FF, 8'h00, 8'h00, 8'h00, 8'h19, 8'h19, 8'hE3, 8'hA3, 1'b0, 0);
      check_seq(1, 9'h1FF, 8'h00, 8'h00, 8'h00, 8'h19, 8'h19, 8'hE3, 8'hA3, 1'b0, 0);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] m;
    int i;
    for (int k = 0; k < 2; k++) begin
      cfg_valid[k] = 1'b0; cfg_mask[k] = '0;
      cfg_pwm_r[k] = '0; cfg_pwm_g[k] = '0; cfg_pwm_b[k] = '0;
      cfg_onr[k] = '0; cfg_ofr[k] = '0; cfg_bcrr[k] = '0; cfg_bcfr[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset", 32'({led_cs[k], led_en[k], led_exe[k], led_addr[k], led_dat[k],
                        busy[k], done[k], cfg_ready[k]}), 32'd0);

    auto_both();

    send(0, 9'h1C0, 8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
    send(1, 9'h003, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 1'b0, 0);
    send(0, 9'h000, 8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
    send(1, 9'h000, 8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
    send(0, 9'h1FF, 8'h80, 8'hFF, 8'h01, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b1, 0);
    send(1, 9'h1C0, 8'h80, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0);

    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 1));
      m = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) m = 9'h000;
      send(i, m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    // Reset during the fourth write, then the power-up sequence reruns
    send(0, 9'h1FF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 1'b0, 4);
    repeat (2) @(negedge clk);
    chk("rst_hold_rdy", 32'({cfg_ready[0], cfg_ready[1], busy[0], busy[1]}), 32'd0);
    auto_both();

    send(1, 9'h1FF, 8'hC0, 8'h40, 8'h02, 8'h19, 8'h19, 8'hE3, 8'hA3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ledda_cfg_seq.md
Name: ledda_cfg_seq

Overview:
Runtime-reconfigurable register-write sequencer for the iCE40UP SB_LEDDA_IP LED-driver bus. It accepts a full RGB/blink/breathe configuration over a valid/ready handshake and writes only the masked registers. It holds LEDDEXE low during writes and re-asserts it on completion. It sits between user logic and SB_LEDDA_IP, and replaces fixed one-shot power-up programming.

Parameters:
SYS_CLK_HZ, 48000000, LEDDCLK frequency; prescale constant PRE = SYS_CLK_HZ/64000 - 1, a 10-bit value.
CR0_MODE, 6'b110101, LEDDCR0[7:2]: EN, FR250, OUTPOL, OUTSKEW, QUICKSTOP, PWM-mode.
GAP_CYCLES, 0, idle bus cycles inserted after each write (0..15).
AUTO_START, 1, run one full sequence with INIT_* values after reset release.
INIT_ONR, 8'h19, default LEDDONR.
INIT_OFR, 8'h19, default LEDDOFR.
INIT_BCRR, 8'hE3, default LEDDBCRR.
INIT_BCFR, 8'hA3, default LEDDBCFR.

Ports:
clk  in  1  LEDDCLK domain clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  sequencer idle and can accept
cfg_mask  in  9  per-register write enable, bit order below
cfg_pwm_r  in  8  LEDDPWRR value
cfg_pwm_g  in  8  LEDDPWRG value
cfg_pwm_b  in  8  LEDDPWRB value
cfg_onr  in  8  LEDDONR value
cfg_ofr  in  8  LEDDOFR value
cfg_bcrr  in  8  LEDDBCRR value
cfg_bcfr  in  8  LEDDBCFR value
led_cs  out  1  to LEDDCS
led_en  out  1  to LEDDDEN
led_exe  out  1  to LEDDEXE
led_addr  out  4  to LEDDADDR[3:0]
led_dat  out  8  to LEDDDAT[7:0]
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a sequence finishes

Behaviour:
- Clocking: single clock; all outputs registered; rst_n is asynchronous assert, synchronous release.
- Reset values: led_cs=0, led_en=0, led_exe=0, led_addr=0, led_dat=0, busy=0, done=0. cfg_ready=0 if AUTO_START, else 1.
- Register index i (mask bit) to address and data:
  - 0: CR0 (4'h8), {CR0_MODE, PRE[9:8]}
  - 1: BR (4'h9), PRE[7:0]
  - 2: ONR (4'hA)
  - 3: OFR (4'hB)
  - 4: BCRR (4'h5)
  - 5: BCFR (4'h6)
  - 6: PWRR (4'h1)
  - 7: PWRG (4'h2)
  - 8: PWRB (4'h3)
- Write order is always ascending i.
- FSM states: IDLE, LOAD, WRITE, GAP, FINISH.
- IDLE: cfg_ready=1, busy=0. cfg_valid&&cfg_ready latches all cfg_* fields and the mask, then goes to LOAD.
- LOAD (1 cycle): busy=1; selects the lowest set mask bit; drives led_exe=0. Empty mask goes to FINISH.
- WRITE (1 cycle per register): led_cs=led_en=1, led_exe=0, addr/data per table; clears the mask bit. Next state is GAP if GAP_CYCLES>0, else WRITE of the next set bit, else FINISH.
- GAP: cs=en=0, exe=0 for exactly GAP_CYCLES cycles, then next write or FINISH.
- FINISH (1 cycle): cs=en=0, led_exe=1, done=1; then IDLE. led_exe stays 1 until the next LOAD.
- Latency: accept at cycle T puts the first write on the bus at T+2. n writes give done at T+2+n*(1+GAP_CYCLES). cfg_ready returns high the following cycle.
- AUTO_START: after reset release, behaves as an accept of mask 9'h1FF with PWM=0 and INIT_* values. cfg_ready stays 0 until that sequence's done.
- cfg_valid while busy is ignored (not queued); the source must hold it until ready.
- Reset mid-sequence: outputs return immediately to reset values; a partial configuration is abandoned. AUTO_START reruns after release.
- Data width: PRE is truncated to 10 bits. PRE>1023 or SYS_CLK_HZ<64000 is an elaboration error.

Optional Feature:
LEDDA_GAMMA_EN:
- Defined: at latch, each PWM field v is stored as (v*v+255)>>8. Examples: 0->0, 128->64, 255->255. A 16-bit product is computed in the accept cycle; latency is unchanged.
- Undefined: PWM fields are stored unmodified.

Decomposition:
- Package ledda_pkg holds:
  - the register address localparams (ADDR_CR0..ADDR_PWRB);
  - the index constants and NUM_REGS=9;
  - the FSM state enum;
  - the function computing PRE.
- Sub-module ledda_gamma: combinational square/round, instantiated only under LEDDA_GAMMA_EN.

Test Plan:
1. AUTO_START=1, release reset -> 9 writes in order 8,9,A,B,5,6,1,2,3 with CR0=D6, BR=ED, ONR=19, OFR=19, BCRR=E3, BCFR=A3, PWM=00. Then done pulse, led_exe=1, cfg_ready=1.
2. Accept mask 9'h1C0 with r/g/b=10/20/30, GAP_CYCLES=0 -> exactly 3 writes (1:10, 2:20, 3:30) on consecutive cycles starting T+2; done at T+5.
3. GAP_CYCLES=3, mask 9'h003 -> writes at T+2 and T+6, cs low in between; done at T+10.
4. Mask 0 -> no cs activity; done at T+2; led_exe=1.
5. Assert rst_n low during the 4th write -> all outputs 0 in the same cycle; a full AUTO_START sequence runs after release.
6. LEDDA_GAMMA_EN, r/g/b = 80/FF/01 -> writes 40/FF/01; cfg_valid pulsed while busy is ignored with no extra writes.
